syscall_unit: RTL

Sequential system-call service stage for the single-cycle MIPS CPU. It sits beside the control decoder: it consumes the decoder's `syscall` strobe and the `$v0` operand (`sys_op`), and it stalls the PC while it serves the call. It serves three calls: signed-decimal integer print over a byte stream, integer read from a byte stream, and exit. For a read, it returns the parsed value on the register write-back path.

---
 rtl/syscall_unit_pkg.sv | 43 ++++
 rtl/syscall_unit_dec_printer.sv | 90 +++++++++
 rtl/syscall_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/syscall_unit_pkg.sv
// syscall_unit_pkg: call codes, ASCII constants, state encoding and the
// powers-of-ten table shared by syscall_unit and syscall_dec_printer.
// The call-code macros mirror instruction_head.v; the guards let an
// already-included instruction_head.v take precedence.
`ifndef SYSCALL_PRINT_INT
`define SYSCALL_PRINT_INT 1
`endif
`ifndef SYSCALL_INPUT_INT
`define SYSCALL_INPUT_INT 5
`endif
`ifndef SYSCALL_EXIT
`define SYSCALL_EXIT 10
`endif
`ifndef SYS_OP_LENGTH
`define SYS_OP_LENGTH 32
`endif

package syscall_unit_pkg;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NL    = 8'h0A;

  typedef enum logic [2:0] {
    IDLE, P_SIGN, P_DIGIT, P_EMIT, R_CHAR, DONE, HALTED
  } sys_state_t;

  // 10^k for digit index k = 0..9
  function automatic logic [31:0] pow10(input logic [3:0] k);
    case (k)
      4'd0:    pow10 = 32'd1;
      4'd1:    pow10 = 32'd10;
      4'd2:    pow10 = 32'd100;
      4'd3:    pow10 = 32'd1000;
      4'd4:    pow10 = 32'd10000;
      4'd5:    pow10 = 32'd100000;
      4'd6:    pow10 = 32'd1000000;
      4'd7:    pow10 = 32'd10000000;
      4'd8:    pow10 = 32'd100000000;
      4'd9:    pow10 = 32'd1000000000;
      default: pow10 = 32'd1;
    endcase
  endfunction
endpackage

// File: rtl/syscall_unit_dec_printer.sv
// syscall_dec_printer: signed decimal printer. Latches |arg|, emits an
// optional '-', then extracts digits 10^9..10^0 by repeated subtraction,
// suppressing leading zeros. Owns the out_* handshake while busy.
module syscall_dec_printer import syscall_unit_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] arg,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  out_data,
  output logic        out_valid
);
  sys_state_t  pstate;
  logic [31:0] mag, pw, mag_sub;
  logic [3:0]  k, digit, dnext;
  logic        started, ge, fin, emit;

  // Digit step: a subtraction that leaves mag < 10^k also closes the digit,
  // so a digit costs max(d,1) cycles instead of d+1.
  always_comb begin
    pw      = pow10(k);
    ge      = mag >= pw;
    mag_sub = mag - pw;
    dnext   = ge ? digit + 4'd1 : digit;
    fin     = !ge || (mag_sub < pw);
    emit    = (dnext != 4'd0) || started || (k == 4'd0);
  end

  assign busy = (pstate != IDLE);
  assign done = (pstate == P_EMIT) && out_ready && (k == 4'd0);

  // Printer sequencer and registered output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate    <= IDLE;
      mag       <= '0;
      k         <= '0;
      digit     <= '0;
      started   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (pstate)
        IDLE: if (start) begin
          // two's-complement negate; 0x80000000 maps to 2147483648 unsigned
          mag     <= arg[31] ? (~arg + 32'd1) : arg;
          k       <= 4'd9;
          digit   <= '0;
          started <= 1'b0;
          if (arg[31]) begin
            out_valid <= 1'b1;
            out_data  <= ASCII_MINUS;
          end
          pstate  <= P_SIGN;
        end
        P_SIGN: if (!out_valid || out_ready) begin
          out_valid <= 1'b0;
          pstate    <= P_DIGIT;
        end
        P_DIGIT: begin
          if (ge) mag <= mag_sub;
          if (!fin) begin
            digit <= dnext;
          end else if (emit) begin
            digit     <= dnext;
            started   <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= ASCII_ZERO + {4'd0, dnext};
            pstate    <= P_EMIT;
          end else begin
            k     <= k - 4'd1;
            digit <= '0;
          end
        end
        P_EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          digit     <= '0;
          if (k == 4'd0) pstate <= IDLE;
          else begin
            k      <= k - 4'd1;
            pstate <= P_DIGIT;
          end
        end
        default: pstate <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/syscall_unit.sv
// syscall_unit: sequential system-call service stage (print int, read int,
// exit). Stalls the PC while a call is in flight and releases it for one
// DONE cycle. Optional macro SYSCALL_ECHO_EN echoes every read byte.
module syscall_unit import syscall_unit_pkg::*; #(
  parameter int SYS_OP_W = `SYS_OP_LENGTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                syscall,
  input  logic [SYS_OP_W-1:0] sys_op,
  input  logic [31:0]         arg,
  output logic                stall,
  output logic [31:0]         rd_data,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                exited
);
  sys_state_t  state;
  logic        op_print, op_input, op_exit, pr_start, pr_busy, pr_done, pr_valid;
  logic [7:0]  pr_data, dval;
  logic [31:0] acc, acc_next;
  logic        neg, first, in_fire, is_digit;

  assign op_print = (sys_op == SYS_OP_W'(`SYSCALL_PRINT_INT));
  assign op_input = (sys_op == SYS_OP_W'(`SYSCALL_INPUT_INT));
  assign op_exit  = (sys_op == SYS_OP_W'(`SYSCALL_EXIT));
  assign pr_start = (state == IDLE) && syscall && op_print;
  assign in_fire  = in_valid && in_ready;
  assign dval     = in_data - ASCII_ZERO;
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign acc_next = acc * 32'd10 + {24'd0, dval};

  // Stall is combinational so the PC freezes in the very cycle of the call
  always_comb begin
    case (state)
      IDLE:    stall = syscall && (op_print || op_input || op_exit);
      DONE:    stall = 1'b0;
      default: stall = 1'b1;
    endcase
  end

  syscall_dec_printer u_printer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (pr_start),
    .arg       (arg),
    .out_ready (out_ready),
    .busy      (pr_busy),
    .done      (pr_done),
    .out_data  (pr_data),
    .out_valid (pr_valid)
  );

`ifdef SYSCALL_ECHO_EN
  logic [7:0] e_data;
  logic       e_valid, nl_pend;
  assign out_valid = pr_valid | e_valid;
  assign out_data  = pr_valid ? pr_data : e_data;
`else
  assign out_valid = pr_valid;
  assign out_data  = pr_data;
`endif

  // Call sequencer: dispatch, integer parse, one-cycle release, halt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      neg      <= 1'b0;
      first    <= 1'b0;
      rd_data  <= '0;
      in_ready <= 1'b0;
      exited   <= 1'b0;
`ifdef SYSCALL_ECHO_EN
      e_data   <= '0;
      e_valid  <= 1'b0;
      nl_pend  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (syscall) begin
          if (op_print) state <= P_SIGN;
          else if (op_input) begin
            acc      <= '0;
            neg      <= 1'b0;
            first    <= 1'b1;
            in_ready <= 1'b1;
            state    <= R_CHAR;
          end else if (op_exit) begin
            exited <= 1'b1;
            state  <= HALTED;
          end
        end
        // printer runs on its own; just wait for its last byte to leave
        P_SIGN: if (pr_done || !pr_busy) state <= DONE;
        R_CHAR: begin
          if (in_fire) begin
            first <= 1'b0;
            if (is_digit) acc <= acc_next;
            else if (in_data == ASCII_MINUS && first) neg <= 1'b1;
            else if (in_data == ASCII_NL) rd_data <= neg ? (32'd0 - acc) : acc;
`ifdef SYSCALL_ECHO_EN
            e_valid  <= 1'b1;
            e_data   <= in_data;
            in_ready <= 1'b0;
            nl_pend  <= (in_data == ASCII_NL);
`else
            if (in_data == ASCII_NL) begin
              in_ready <= 1'b0;
              state    <= DONE;
            end
`endif
          end
`ifdef SYSCALL_ECHO_EN
          // finish only once the echoed newline has been taken
          if (e_valid && out_ready) begin
            e_valid <= 1'b0;
            if (nl_pend) state <= DONE;
            else in_ready <= 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
